// File: rtl/dma_avmm_burst_responder.sv
// dma_avmm_burst_responder
//    Avalon-MM burst responder backed by an on-chip RAM. It sits at the far
//    end of the DMA local-memory read and write initiators. It is used as a
//    local-memory stand-in for loopback, bring-up and scratch buffers.
//
//    Each burst carries a single command. Address and burstcount are taken
//    from the first beat only. Write beats land at base+k. A read command
//    makes the responder issue one RAM read per cycle. Data comes back in
//    order on readdatavalid, exactly READ_LATENCY cycles after each beat is
//    issued.
//
// Ports
//    clk            clock
//    reset          synchronous, active-high; RAM contents are kept
//    address        word address (first beat of a burst)
//    burstcount     beats in the burst (first beat); 0 counts as 1 and is flagged
//    read / write   command / beat requests
//    writedata      write beat data
//    byteenable     per-byte write enable (writes only)
//    waitrequest    1 = the presented read/write is not accepted this cycle
//    readdata       read beat data
//    readdatavalid  readdata holds a valid beat this cycle
//    rd_beat_cnt    read beats returned (wraps)
//    wr_beat_cnt    write beats committed (wraps)
//    protocol_err   sticky flag for illegal request combinations
module dma_avmm_burst_responder #(
   parameter int ADDR_WIDTH       = 10,
   parameter int DATA_WIDTH       = 512,
   parameter int BURSTCOUNT_WIDTH = 7,
   parameter int READ_LATENCY     = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [ADDR_WIDTH-1:0]       address,
   input  logic [BURSTCOUNT_WIDTH-1:0] burstcount,
   input  logic                        read,
   input  logic                        write,
   input  logic [DATA_WIDTH-1:0]       writedata,
   input  logic [DATA_WIDTH/8-1:0]     byteenable,
   output logic                        waitrequest,
   output logic [DATA_WIDTH-1:0]       readdata,
   output logic                        readdatavalid,
   output logic [31:0]                 rd_beat_cnt,
   output logic [31:0]                 wr_beat_cnt,
   output logic                        protocol_err
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int DEPTH    = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WR_BURST = 2'd1,
      RD_BURST = 2'd2
   } state_t;

   state_t                      state_reg, state_next;
   logic [BURSTCOUNT_WIDTH-1:0] cnt_reg, cnt_next;
   logic [BURSTCOUNT_WIDTH-1:0] len_reg, len_next;
   logic [ADDR_WIDTH-1:0]       base_reg, base_next;

   logic                        wr_en;
   logic                        rd_en;
   logic [ADDR_WIDTH-1:0]       wr_addr;
   logic [ADDR_WIDTH-1:0]       rd_addr;
   logic                        err_set;

   logic [BURSTCOUNT_WIDTH-1:0] first_len;
   logic [ADDR_WIDTH-1:0]       burst_addr;
   logic                        last_beat;

   logic [READ_LATENCY-1:0]     vld_reg;
   logic [31:0]                 rd_cnt_reg;
   logic [31:0]                 wr_cnt_reg;
   logic                        err_reg;

   // A zero burstcount behaves as a single beat.
   assign first_len  = (burstcount == '0) ? BURSTCOUNT_WIDTH'(1) : burstcount;
   // Address arithmetic wraps naturally at the top of the RAM.
   assign burst_addr = base_reg + ADDR_WIDTH'(cnt_reg);
   assign last_beat  = (cnt_reg == (len_reg - BURSTCOUNT_WIDTH'(1)));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         len_reg   <= '0;
         base_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         len_reg   <= len_next;
         base_reg  <= base_next;
      end
   end

   always_comb begin
      state_next  = state_reg;
      cnt_next    = cnt_reg;
      len_next    = len_reg;
      base_next   = base_reg;
      waitrequest = 1'b1;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      wr_addr     = address;
      rd_addr     = address;
      err_set     = 1'b0;

      if (!reset) begin
         case (state_reg)
            IDLE: begin
               waitrequest = read & write;
               if (read && write) begin
                  // Ambiguous request: stall both and flag it.
                  err_set = 1'b1;
               end else if (write) begin
                  wr_en     = 1'b1;
                  wr_addr   = address;
                  err_set   = (burstcount == '0);
                  base_next = address;
                  len_next  = first_len;
                  cnt_next  = BURSTCOUNT_WIDTH'(1);
                  if (first_len != BURSTCOUNT_WIDTH'(1)) begin
                     state_next = WR_BURST;
                  end
               end else if (read) begin
                  rd_en     = 1'b1;
                  rd_addr   = address;
                  err_set   = (burstcount == '0);
                  base_next = address;
                  len_next  = first_len;
                  cnt_next  = BURSTCOUNT_WIDTH'(1);
                  if (first_len != BURSTCOUNT_WIDTH'(1)) begin
                     state_next = RD_BURST;
                  end
               end
            end

            WR_BURST: begin
               // Writes keep flowing. A read during a write burst is illegal
               // and is held off.
               waitrequest = read;
               if (read) begin
                  err_set = 1'b1;
               end else if (write) begin
                  wr_en    = 1'b1;
                  wr_addr  = burst_addr;
                  cnt_next = cnt_reg + BURSTCOUNT_WIDTH'(1);
                  if (last_beat) begin
                     state_next = IDLE;
                  end
               end
            end

            RD_BURST: begin
               // One RAM read per cycle, back to back, with no gaps.
               rd_en    = 1'b1;
               rd_addr  = burst_addr;
               cnt_next = cnt_reg + BURSTCOUNT_WIDTH'(1);
               if (last_beat) begin
                  state_next = IDLE;
               end
            end

            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   // The RAM is split into byte lanes. Each lane owns its byte-enable write
   // port and its own read-data pipeline: a registered RAM output followed
   // by READ_LATENCY-1 delay stages.
   genvar gi;
   generate
      for (gi = 0; gi < BE_WIDTH; gi++) begin : g_lane
         logic [7:0] mem [DEPTH];
         logic [7:0] pipe [READ_LATENCY];

         always_ff @(posedge clk) begin
            if (wr_en && byteenable[gi]) begin
               mem[wr_addr] <= writedata[gi*8 +: 8];
            end
            if (rd_en) begin
               pipe[0] <= mem[rd_addr];
            end
            for (int s = 1; s < READ_LATENCY; s++) begin
               pipe[s] <= pipe[s-1];
            end
         end

         assign readdata[gi*8 +: 8] = pipe[READ_LATENCY-1];
      end
   endgenerate

   // The valid pipeline runs alongside the data stages. It is the only part
   // of the read path that is reset, so pending beats vanish on reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         vld_reg <= '0;
      end else begin
         vld_reg[0] <= rd_en;
         for (int s = 1; s < READ_LATENCY; s++) begin
            vld_reg[s] <= vld_reg[s-1];
         end
      end
   end

   assign readdatavalid = vld_reg[READ_LATENCY-1];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_cnt_reg <= '0;
         wr_cnt_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         if (readdatavalid) begin
            rd_cnt_reg <= rd_cnt_reg + 32'd1;
         end
         if (wr_en) begin
            wr_cnt_reg <= wr_cnt_reg + 32'd1;
         end
         if (err_set) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign rd_beat_cnt  = rd_cnt_reg;
   assign wr_beat_cnt  = wr_cnt_reg;
   assign protocol_err = err_reg;

endmodule
